// File: rtl/sha_round_controller_pkg.sv
// Shared types and defaults for the SHA-2 round controller slice.
package sha_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROUND  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4
  } ctrl_state_t;

  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_OUT_WORDS = 8;
  localparam int SHA224_OUT_WORDS = 7;

  // Index width for a 0..n-1 counter, never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sha_round_controller_if.sv
// Block-input and digest-output handshakes between the controller and its neighbours.
interface sha_round_controller_if
  import sha_ctrl_pkg::*;
#(
  parameter int OUT_WORDS = SHA256_OUT_WORDS
) ();

  localparam int OW = idx_width(OUT_WORDS);

  logic          blk_valid;
  logic          blk_ready;
  logic          blk_first;
  logic          blk_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_idx;

  modport master (
    output blk_valid, blk_first, blk_last, out_ready,
    input  blk_ready, out_valid, out_idx
  );

  modport slave (
    input  blk_valid, blk_first, blk_last, out_ready,
    output blk_ready, out_valid, out_idx
  );

endinterface

// File: rtl/sha_round_controller_wrap_counter.sv
// Modulo-MAX counter with synchronous clear; wrap flags the final counted step.
module wrap_counter
  import sha_ctrl_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = idx_width(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] ONE  = W'(1'b1);

  assign wrap = en && (count == LAST);

  // Count register: clear dominates, wraps to zero after LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : (count + ONE);
    end
  end

endmodule

// File: rtl/sha_round_controller.sv
// SHA-2 round sequencer: accepts blocks, chains messages, runs ROUNDS rounds per
// block, strobes the hash update and serialises OUT_WORDS digest words.
module sha_round_controller
  import sha_ctrl_pkg::*;
#(
  parameter int ROUNDS    = SHA256_ROUNDS,
  parameter int OUT_WORDS = SHA256_OUT_WORDS,
  parameter int RW        = idx_width(ROUNDS),
  parameter int OW        = idx_width(OUT_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   abort,
  sha_round_controller_if.slave  bus,
  output logic                   load_block,
  output logic                   init_iv,
  output logic                   round_en,
  output logic [RW-1:0]          round_idx,
  output logic                   update_hash,
  output logic                   busy,
  output logic                   seq_err
);

  ctrl_state_t   state_r;
  ctrl_state_t   next_state_s;
  logic          last_r;
  logic          hs_s;
  logic          out_fire_s;
  logic          round_wrap_s;
  logic          out_wrap_s;
  logic [OW-1:0] out_cnt_s;

  assign bus.blk_ready = (state_r == ST_IDLE) || (state_r == ST_WAIT);
  // abort wins over a simultaneous handshake, so the block is not taken.
  assign hs_s          = bus.blk_valid && bus.blk_ready && !abort;
  assign load_block    = hs_s;
  assign init_iv       = hs_s && bus.blk_first;
  assign round_en      = (state_r == ST_ROUND);
  assign update_hash   = (state_r == ST_UPDATE);
  assign bus.out_valid = (state_r == ST_OUTPUT);
  assign out_fire_s    = bus.out_valid && bus.out_ready;
  assign busy          = (state_r != ST_IDLE);
  assign bus.out_idx   = out_cnt_s;

  wrap_counter #(.MAX(ROUNDS)) u_round_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (round_en),
    .clr     (abort),
    .count   (round_idx),
    .wrap    (round_wrap_s)
  );

  wrap_counter #(.MAX(OUT_WORDS)) u_out_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (out_fire_s),
    .clr     (abort),
    .count   (out_cnt_s),
    .wrap    (out_wrap_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Remembers whether the block in flight closes its message.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= 1'b0;
    end else if (abort) begin
      last_r <= 1'b0;
    end else if (hs_s) begin
      last_r <= bus.blk_last;
    end
  end

  // Next-state logic and first/last protocol checking.
  always_comb begin
    next_state_s = state_r;
    seq_err      = 1'b0;
    if (abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            if (bus.blk_first) begin
              next_state_s = ST_ROUND;
            end else begin
              seq_err = 1'b1;
            end
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_ROUND: begin
          if (round_wrap_s) begin
            next_state_s = ST_UPDATE;
          end else begin
            next_state_s = ST_ROUND;
          end
        end
        ST_UPDATE: begin
          if (last_r) begin
            next_state_s = ST_OUTPUT;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        // A first block here restarts the message; flag the abandoned one.
        ST_WAIT: begin
          if (hs_s) begin
            next_state_s = ST_ROUND;
            seq_err      = bus.blk_first;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        ST_OUTPUT: begin
          if (out_wrap_s) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_OUTPUT;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_controller.sv
// Directed bench: 64/8 controller for the main flows, 4/7 controller for the small configuration.
module tb_sha_round_controller;

  logic clk;
  logic reset_n;
  logic abort;

  sha_round_controller_if #(.OUT_WORDS(8)) ia ();
  sha_round_controller_if #(.OUT_WORDS(7)) ib ();

  logic       a_load, a_init, a_ren, a_upd, a_busy, a_seq;
  logic [5:0] a_ridx;
  logic       b_load, b_init, b_ren, b_upd, b_busy, b_seq;
  logic [1:0] b_ridx;

  int n_cmp = 0;
  int n_err = 0;
  int a_seq_cnt = 0;
  int a_upd_cnt = 0;
  int s0;
  int u0;

  sha_round_controller #(.ROUNDS(64), .OUT_WORDS(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .abort(abort), .bus(ia.slave),
    .load_block(a_load), .init_iv(a_init), .round_en(a_ren), .round_idx(a_ridx),
    .update_hash(a_upd), .busy(a_busy), .seq_err(a_seq)
  );

  sha_round_controller #(.ROUNDS(4), .OUT_WORDS(7)) dut_b (
    .clk(clk), .reset_n(reset_n), .abort(abort), .bus(ib.slave),
    .load_block(b_load), .init_iv(b_init), .round_en(b_ren), .round_idx(b_ridx),
    .update_hash(b_upd), .busy(b_busy), .seq_err(b_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_seq === 1'b1) a_seq_cnt <= a_seq_cnt + 1;
    if (a_upd === 1'b1) a_upd_cnt <= a_upd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic f, input logic l, input logic ab, input logic rdy);
    @(negedge clk);
    ia.blk_valid = v; ia.blk_first = f; ia.blk_last = l; ia.out_ready = rdy;
    ib.blk_valid = v; ib.blk_first = f; ib.blk_last = l; ib.out_ready = rdy;
    abort = ab;
    #1;
  endtask

  task automatic tick();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    abort   = 1'b0;
    ia.blk_valid = 1'b0; ia.blk_first = 1'b0; ia.blk_last = 1'b0; ia.out_ready = 1'b1;
    ib.blk_valid = 1'b0; ib.blk_first = 1'b0; ib.blk_last = 1'b0; ib.out_ready = 1'b1;
    #3;
    chk("rst_ready", 32'(ia.blk_ready), 1);
    chk("rst_busy",  32'(a_busy), 0);
    chk("rst_load",  32'(a_load), 0);
    chk("rst_ren",   32'(a_ren), 0);
    chk("rst_ridx",  32'(a_ridx), 0);
    chk("rst_oval",  32'(ia.out_valid), 0);
    chk("rst_oidx",  32'(ia.out_idx), 0);
    chk("rst_seq",   32'(a_seq), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single-block message.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t1_load", 32'(a_load), 1);
    chk("t1_init", 32'(a_init), 1);
    for (int c = 1; c <= 64; c++) begin
      tick();
      chk("t1_ridx", 32'(a_ridx), c - 1);
      chk("t1_ren",  32'(a_ren), 1);
    end
    tick();
    chk("t1_upd",      32'(a_upd), 1);
    chk("t1_ren_off",  32'(a_ren), 0);
    chk("t1_ridx_wrap", 32'(a_ridx), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t1_oval", 32'(ia.out_valid), 1);
      chk("t1_oidx", 32'(ia.out_idx), k);
    end
    tick();
    chk("t1_ready_end", 32'(ia.blk_ready), 1);
    chk("t1_busy_end",  32'(a_busy), 0);

    // Two-block message.
    s0 = a_seq_cnt;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_initA", 32'(a_init), 1);
    repeat (64) tick();
    tick();
    chk("t2_updA", 32'(a_upd), 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_wait_ready", 32'(ia.blk_ready), 1);
    chk("t2_wait_busy",  32'(a_busy), 1);
    chk("t2_loadB",      32'(a_load), 1);
    chk("t2_initB",      32'(a_init), 0);
    repeat (64) tick();
    tick();
    chk("t2_updB", 32'(a_upd), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_oidx", 32'(ia.out_idx), k);
    end
    tick();
    chk("t2_busy_end", 32'(a_busy), 0);
    chk("t2_no_seq",   32'(a_seq_cnt - s0), 0);

    // Backpressure at word 3.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (65) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_oidx", 32'(ia.out_idx), k);
    end
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_hold_idx", 32'(ia.out_idx), 3);
      chk("t3_hold_val", 32'(ia.out_valid), 1);
    end
    tick();
    chk("t3_resume", 32'(ia.out_idx), 3);
    for (int k = 4; k < 8; k++) begin
      tick();
      chk("t3_oidx_tail", 32'(ia.out_idx), k);
    end
    tick();
    chk("t3_busy_end", 32'(a_busy), 0);

    // Abort at round 20.
    u0 = a_upd_cnt;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) tick();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_ridx20", 32'(a_ridx), 20);
    tick();
    chk("t4_busy", 32'(a_busy), 0);
    chk("t4_ren",  32'(a_ren), 0);
    chk("t4_ridx", 32'(a_ridx), 0);
    repeat (70) tick();
    chk("t4_no_upd", 32'(a_upd_cnt - u0), 0);

    // Abort together with a handshake in WAIT.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (65) tick();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_ready", 32'(ia.blk_ready), 1);
    chk("t5_load",  32'(a_load), 0);
    chk("t5_init",  32'(a_init), 0);
    chk("t5_seq",   32'(a_seq), 0);
    tick();
    chk("t5_busy", 32'(a_busy), 0);
    chk("t5_ren",  32'(a_ren), 0);

    // Non-first block while idle.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_seq",  32'(a_seq), 1);
    chk("t6_load", 32'(a_load), 1);
    chk("t6_init", 32'(a_init), 0);
    tick();
    chk("t6_seq_off", 32'(a_seq), 0);
    chk("t6_busy",    32'(a_busy), 0);

    // First block while waiting, then reset mid-output.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (65) tick();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t7_seq",  32'(a_seq), 1);
    chk("t7_init", 32'(a_init), 1);
    chk("t7_load", 32'(a_load), 1);
    tick();
    chk("t7_ren",  32'(a_ren), 1);
    chk("t7_ridx", 32'(a_ridx), 0);
    repeat (63) tick();
    tick();
    chk("t7_upd", 32'(a_upd), 1);
    tick();
    chk("t7_oval", 32'(ia.out_valid), 1);
    tick();
    tick();
    chk("t7_oidx2", 32'(ia.out_idx), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_oval",  32'(ia.out_valid), 0);
    chk("t7_rst_busy",  32'(a_busy), 0);
    chk("t7_rst_ready", 32'(ia.blk_ready), 1);
    chk("t7_rst_oidx",  32'(ia.out_idx), 0);
    chk("t7_rst_upd",   32'(a_upd), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Small configuration: ROUNDS=4, OUT_WORDS=7.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("b_load", 32'(b_load), 1);
    chk("b_init", 32'(b_init), 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("b_ridx", 32'(b_ridx), c - 1);
      chk("b_ren",  32'(b_ren), 1);
    end
    tick();
    chk("b_upd", 32'(b_upd), 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("b_oval", 32'(ib.out_valid), 1);
      chk("b_oidx", 32'(ib.out_idx), k);
    end
    tick();
    chk("b_ready_end", 32'(ib.blk_ready), 1);
    chk("b_busy_end",  32'(b_busy), 0);
    chk("b_seq",       32'(b_seq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha_round_controller.md
# sha_round_controller

Parametrised control FSM for the SHA-2 datapath. It accepts message blocks over a valid/ready handshake and chains multi-block messages. It sequences the round counter for `hash_core` and `message_schedule`, issues the hash-update strobe, and serialises digest words out under backpressure. It replaces the fixed 64-round, fixed-output-window controller and sits between the block input buffer and the `hash_core` / `message_schedule` pair.

## Interface
- `ROUNDS`, 64, rounds per block; minimum 2.
- `OUT_WORDS`, 8, digest words emitted per message, 1..16 (8 = SHA-256, 7 = SHA-224).
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `blk_valid` input 1: block present on input bus.
- `blk_ready` output 1: controller can accept a block.
- `blk_first` input 1: block starts a message; qualified by handshake.
- `blk_last` input 1: block ends a message; qualified by handshake.
- `abort` input 1: synchronous cancel.
- `load_block` output 1: message schedule loads W[0..15].
- `init_iv` output 1: `hash_core` loads H from IV.
- `round_en` output 1: one round executes this cycle.
- `round_idx` output clog2(ROUNDS): current round number.
- `update_hash` output 1: H += working variables.
- `out_valid` output 1: `out_idx` digest word valid.
- `out_ready` input 1: downstream accepts the word.
- `out_idx` output clog2(OUT_WORDS) (min 1): digest word select.
- `busy` output 1: state is not IDLE.
- `seq_err` output 1: one-cycle pulse on a first/last protocol violation.

## Operation
- States: IDLE, ROUND, UPDATE, WAIT, OUTPUT.
- `blk_ready` = state is IDLE or WAIT. It is combinational from state only.
- Handshake is `blk_valid && blk_ready`.
  - `load_block` = handshake, same cycle.
  - `init_iv` = handshake && `blk_first`.
  - `blk_last` is latched into `last_q` at the handshake.
- IDLE:
  - Handshake with `blk_first`=1 → ROUND, `round_idx`←0.
  - Handshake with `blk_first`=0 → `seq_err` pulse; block is consumed and dropped (`load_block` still pulses, ignored downstream). State stays IDLE.
- ROUND: `round_en`=1. `round_idx` increments every cycle. At `round_idx`=ROUNDS-1 → UPDATE; the counter wraps to 0.
- UPDATE: `update_hash`=1 for one cycle. Then → OUTPUT if `last_q`, else → WAIT.
- WAIT:
  - Any handshake → ROUND.
  - If `blk_first`=1: `seq_err` pulse plus `init_iv`. The previous message is discarded and a new message starts.
- OUTPUT:
  - `out_valid`=1.
  - `out_idx` advances only on `out_valid && out_ready`.
  - Handshake at `out_idx`=OUT_WORDS-1 → IDLE; `out_idx`←0.
- `abort`=1 in any state → IDLE at the next edge. Counters and `last_q` are cleared. `abort` beats a simultaneous block handshake: no `load_block` or `init_iv` that cycle.
- `busy` = state≠IDLE.

## Timing
- Reset values (asserted immediately, asynchronously): state IDLE, `blk_ready`=1, all other outputs 0, counters 0, `last_q`=0.
- Cycle numbering with handshake at cycle 0:
  - Cycles 1..ROUNDS: ROUND, `round_idx`=cycle-1.
  - Cycle ROUNDS+1: UPDATE.
  - Last block with `out_ready` held high: OUTPUT on cycles ROUNDS+2..ROUNDS+1+OUT_WORDS; IDLE at ROUNDS+2+OUT_WORDS.
- Non-last block: WAIT from cycle ROUNDS+2. Sustained throughput is one block per ROUNDS+2 cycles.
- No outputs are registered beyond the state and counters.
- `round_idx` and `out_idx` hold their value outside their own state. `round_idx` is 0 outside ROUND except during the wrap cycle.
- Reset mid-operation abandons all state with no flush cycles.

## Structure
- Shared package `sha_ctrl_pkg` holds:
  - the state typedef (3-bit encoding: IDLE=0, ROUND=1, UPDATE=2, WAIT=3, OUTPUT=4);
  - default ROUNDS/OUT_WORDS constants for SHA-224/256.
- Use one sub-module, `wrap_counter` (parameter MAX, inputs `en`/`clr`, outputs `count`/`wrap`). It is instantiated twice: once for rounds, once for output words.

## Test plan
- Single-block message, defaults: handshake at cycle 0 with first=last=1 → `load_block` and `init_iv` at 0, `round_idx` 0..63 on cycles 1..64, `update_hash` at 65, `out_idx` 0..7 on 66..73, `blk_ready`=1 at 74.
- Two-block message: block A (first=1, last=0) at cycle 0, block B (first=0, last=1) at cycle 66 → `init_iv` only at 0, `update_hash` at 65 and 131, outputs on 132..139, no `seq_err`.
- Backpressure: `out_ready`=0 for 3 cycles while `out_idx`=3 → `out_idx` holds 3, `out_valid` stays 1, last word accepted 3 cycles later than the no-stall case.
- Abort at `round_idx`=20, plus abort together with a handshake in WAIT → IDLE next cycle, `round_en`=0, no `update_hash`, no `load_block` in the abort cycle.
- Protocol and reset:
  - first=0 block in IDLE → `seq_err` pulse, state stays IDLE.
  - first=1 block in WAIT → `seq_err` plus `init_iv`.
  - `reset_n` low mid-OUTPUT → all outputs at reset values without waiting for a clock edge.
- ROUNDS=4, OUT_WORDS=7: `round_idx` 0..3 on cycles 1..4, `update_hash` at 5, `out_idx` 0..6 on 6..12, IDLE at 13.
